// File: rtl/dino_input_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dino_input_pkg
//  Description : Shared types and timing constants for the Dino input path
//                (debouncer and button event decoder).
//  Revision    : 1.0 - initial release
// ============================================================================
package dino_input_pkg;

    // Decoder hold-tracking states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_t;

    // Debouncer auto-repeat toggle half-period while a button is held
    localparam int DEBOUNCE_HALF_PERIOD = 256;

    // Silence needed before a release is declared; must exceed the toggle half-period
    localparam int DEFAULT_WINDOW       = 300;

    // Continuous hold before a long press is reported
    localparam int DEFAULT_LONG_CYCLES  = 4096;

    // Counter width able to hold max(DEFAULT_WINDOW, DEFAULT_LONG_CYCLES)
    localparam int DEFAULT_CNT_W        = 16;

endpackage : dino_input_pkg
`default_nettype wire

// File: rtl/activity_timer.sv
`default_nettype none
// ============================================================================
//  Module      : activity_timer
//  Description : Saturating up-counter with synchronous clear and increment
//                enable; flags when the count equals LIMIT.
//  Revision    : 1.0 - initial release
// ============================================================================
module activity_timer #(
    parameter int CNT_W = 16,
    parameter int LIMIT = 299,
    parameter int SAT   = 300
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic at_limit
);

    localparam logic [CNT_W-1:0] c_limit = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] c_sat   = CNT_W'(SAT);

    logic [CNT_W-1:0] r_count;

    // Count up while enabled, stick at SAT so the value never wraps; clear wins
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (inc && (r_count != c_sat)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign at_limit = (r_count == c_limit);

endmodule : activity_timer
`default_nettype wire

// File: rtl/button_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_decoder
//  Description : Collapses the debouncer's auto-repeat toggle train into one
//                hold interval, emits press / release / long-press pulses and
//                raises a jump request with a req/ack handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_event_decoder
    import dino_input_pkg::*;
#(
    parameter int WINDOW      = DEFAULT_WINDOW,
    parameter int LONG_CYCLES = DEFAULT_LONG_CYCLES,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic button_state,
    input  logic jump_ack,
    output logic jump_req,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic held,
    output logic ducking
);

    state_t r_state;
    state_t w_state_next;

    logic r_prev_bs;
    logic r_seen_low;
    logic r_jump_req;
    logic r_press_pulse;
    logic r_release_pulse;
    logic r_long_pulse;
    logic r_held;
    logic r_ducking;

    logic w_edge;
    logic w_in_hold;
    logic w_press;
    logic w_release;
    logic w_long;
    logic w_hold_at_long;
    logic w_silence_at_window;
    logic w_silence_clear;
    logic w_silence_inc;

    logic w_jump_req_d;
    logic w_held_d;
    logic w_ducking_d;

    assign w_edge    = button_state ^ r_prev_bs;
    assign w_in_hold = (r_state != ST_IDLE);

    // A press needs a genuine 0->1 transition; r_seen_low keeps a level that was
    // already high across reset from being mistaken for a new press.
    assign w_press   = (r_state == ST_IDLE) && button_state && !r_prev_bs && r_seen_low;

    // Release beats long-press when both land on the same edge
    assign w_release = w_in_hold && w_silence_at_window && !button_state;
    assign w_long    = (r_state == ST_PRESSED) && w_hold_at_long && !w_release;

    // Silence restarts on any edge or while the level is high
    assign w_silence_clear = !w_in_hold || w_edge || button_state;
    assign w_silence_inc   = w_in_hold && !w_edge && !button_state;

    activity_timer #(
        .CNT_W (CNT_W),
        .LIMIT (LONG_CYCLES - 1),
        .SAT   (LONG_CYCLES)
    ) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (!w_in_hold),
        .inc      (w_in_hold),
        .at_limit (w_hold_at_long)
    );

    activity_timer #(
        .CNT_W (CNT_W),
        .LIMIT (WINDOW - 1),
        .SAT   (WINDOW)
    ) u_silence_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_silence_clear),
        .inc      (w_silence_inc),
        .at_limit (w_silence_at_window)
    );

    // State, edge history and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_prev_bs       <= 1'b0;
            r_seen_low      <= !button_state;
            r_jump_req      <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            r_held          <= 1'b0;
            r_ducking       <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_prev_bs       <= button_state;
            r_seen_low      <= r_seen_low || !button_state;
            r_jump_req      <= w_jump_req_d;
            r_press_pulse   <= w_press;
            r_release_pulse <= w_release;
            r_long_pulse    <= w_long;
            r_held          <= w_held_d;
            r_ducking       <= w_ducking_d;
        end
    end

    // Next-state decision for the hold tracker
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_press) begin
                    w_state_next = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (w_release) begin
                    w_state_next = ST_IDLE;
                end else if (w_long) begin
                    w_state_next = ST_LONG;
                end
            end
            ST_LONG: begin
                if (w_release) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Next values of the level outputs and the jump handshake
    always_comb begin
        w_held_d     = (w_state_next != ST_IDLE);
        w_ducking_d  = (w_state_next == ST_LONG);
        // A press sets the request even if ack arrives on the same edge
        w_jump_req_d = w_press || (r_jump_req && !jump_ack);
    end

    assign jump_req      = r_jump_req;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign long_pulse    = r_long_pulse;
    assign held          = r_held;
    assign ducking       = r_ducking;

endmodule : button_event_decoder
`default_nettype wire
